pipe_stage_reg: RTL

// - Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) replacing per-stage hand-written latches.
// - Carries one WIDTH-bit packed payload (operands, addresses, npc, WB/MEM/EX ctrl fields) with valid/ready handshake.
// - Supports stall (downstream back-pressure), flush (bubble insertion) and an optional skid buffer.
// - Sits between two pipeline stages; one instance per stage boundary.

---
 rtl/pipe_stage_reg.sv | 109 ++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready inter-stage pipeline register with flush
// Optional 1-entry skid buffer enabled by defining PIPE_STAGE_SKID_EN.
module pipe_stage_reg #(
  parameter int               WIDTH          = 64,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0,
  parameter bit               CLEAR_ON_FLUSH = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] w_out_next;
  logic             w_accept;
  logic             w_emit;
  logic             w_load_out;

`ifdef PIPE_STAGE_SKID_EN
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_free;
  logic             w_load_skid;
  logic             w_out_from_skid;
`endif

  assign w_accept = in_valid & in_ready;
  assign w_emit   = out_valid & out_ready;
  assign out_data = r_out_data;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= ST_EMPTY;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) w_next_state = ST_FULL;
        ST_FULL: begin
`ifdef PIPE_STAGE_SKID_EN
          if (w_accept && !out_ready) w_next_state = ST_SKID;
          else
`endif
          if (w_emit && !w_accept) w_next_state = ST_EMPTY;
        end
        ST_SKID:  if (w_emit) w_next_state = ST_FULL;
        default:  w_next_state = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (r_state != ST_EMPTY);
`ifdef PIPE_STAGE_SKID_EN
    // Registered ready: no combinational path from out_ready.
    in_ready  = r_skid_free & ~RST & ~flush;
`else
    in_ready  = ~RST & ~flush & ((r_state == ST_EMPTY) | out_ready);
`endif
  end

`ifdef PIPE_STAGE_SKID_EN
  assign w_load_skid     = (r_state == ST_FULL) & w_accept & ~out_ready;
  assign w_out_from_skid = (r_state == ST_SKID);
  assign w_load_out      = w_out_from_skid ? w_emit : (w_accept & ~w_load_skid);
  assign w_out_next      = w_out_from_skid ? r_skid_data : in_data;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_skid_data <= RESET_VAL;
      r_skid_free <= 1'b1;
    end else begin
      if (w_load_skid && !flush) r_skid_data <= in_data;
      r_skid_free <= (w_next_state != ST_SKID);
    end
  end
`else
  assign w_load_out = w_accept;
  assign w_out_next = in_data;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_out_data <= RESET_VAL;
    end else if (flush) begin
      if (CLEAR_ON_FLUSH) r_out_data <= RESET_VAL;
    end else if (w_load_out) begin
      r_out_data <= w_out_next;
    end
  end

endmodule
